tt_uart_tx: RTL
===============

TT_UART_TX -- requirements
Module: tt_uart_tx

Interface
REQ-001 SHALL have parameter DIV_W, default 12, width of the bit-period divisor.
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port data_in, input, 8, byte to transmit.
REQ-006 SHALL have port data_valid, input, 1, data_in is valid.
REQ-007 SHALL have port data_ready, output, 1, block can accept a byte.
REQ-008 SHALL have port baud_div, input, DIV_W, bit period in clocks minus 1.
REQ-009 SHALL have port tx, output, 1, serial line; idle high.
REQ-010 SHALL have port busy, output, 1, frame in progress.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a byte on any rising edge where data_valid and data_ready are both 1.
- Acceptance latches data_in and baud_div.
- A later baud_div change never affects the frame in flight.
REQ-013 SHALL hold each bit on tx for exactly baud_div+1 clocks; baud_div=0 gives 1 clock per bit.
REQ-014 SHALL drive tx low (start bit) from the cycle after acceptance.
REQ-015 SHALL then send 8 data bits LSB first, then the optional parity bit (REQ-024), then STOP_BITS stop bits high.
REQ-016 SHALL assert data_ready in IDLE and in the final clock of the last stop bit, and only then.
- Acceptance in that final clock SHALL start the next start bit on the following cycle.
- Back-to-back frames therefore have no idle gap.
REQ-017 SHALL assert busy from the cycle after acceptance until the end of the last stop bit.
- busy SHALL stay 1 across back-to-back frames.
REQ-018 SHALL keep tx high whenever in IDLE.
REQ-019 SHALL ignore data_valid while data_ready is 0; no byte is queued or dropped silently.
REQ-020 SHALL NOT require data_valid to be held after acceptance.
REQ-021 SHALL implement the bit counter (0..7) and the divisor counter with no wrap beyond the terminal count.
- Terminal counts: bit counter 7; divisor counter equal to the latched baud_div.

Reset
REQ-022 SHALL, on the clock edge with rst=1, force:
- state IDLE
- tx=1, busy=0, data_ready=0 during that reset cycle, then data_ready=1
- all counters and latches cleared
REQ-023 SHALL, if rst occurs mid-frame, abandon the frame; tx is high from the next edge and no partial bits follow.

Configuration
REQ-024 SHALL compile an even-parity bit between the last data bit and the first stop bit when macro TT_UART_TX_PARITY_EN is defined.
- Parity bit = XOR of the 8 data bits.
- Without the macro, the PARITY state and parity logic SHALL be absent and DATA goes directly to STOP.
- Frame length: 10 bit periods with 1 stop bit and no parity; 11 with parity.

Structure
REQ-025 SHALL take from shared package tt_uart_pkg:
- the state enum typedef
- constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1
REQ-026 SHALL use one sub-module, tt_uart_baud_tick.
- Loadable down-counter that pulses once per bit period from the latched divisor.
- Restarted on every acceptance.

Verification
REQ-027 SHALL cover single byte: baud_div=3, data_in=0x55 accepted.
- Expected: tx low 4 clocks, then bits 1,0,1,0,1,0,1,0 of 4 clocks each, then high 4 clocks.
- busy high 40 clocks.
REQ-028 SHALL cover back-to-back: 0xA5 then 0x3C, data_valid held, baud_div=0.
- Expected: 20 contiguous bit periods, no idle cycle; data_ready pulses exactly once between the frames.
REQ-029 SHALL cover divisor change mid-frame: baud_div 2→7 during the data bits.
- Expected: the current frame keeps 3-clock bits; the next frame uses 8-clock bits.
REQ-030 SHALL cover reset mid-frame: rst=1 for 1 cycle during data bit 4.
- Expected: tx=1, busy=0 on the next edge; data_ready=1 the following cycle.
REQ-031 SHALL cover parity (with TT_UART_TX_PARITY_EN): data 0x07.
- Expected: parity bit 1; 11-period frame.
- Without the macro, the same byte gives a 10-period frame.
REQ-032 SHALL cover data_valid pulsed while busy (not at the final stop clock).
- Expected: no acceptance; the tx waveform is unchanged.

Source files
------------

// File: rtl/tt_uart_pkg.sv
// Shared UART frame types and constants.
// TT_UART_TX_PARITY_EN adds the PARITY state to the frame sequence.
package tt_uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned UART_BIT_CNT_W  = $clog2(UART_DATA_BITS);
    localparam int unsigned UART_STATE_W    = 3;

`ifdef TT_UART_TX_PARITY_EN
    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;
`else
    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } uart_state_e;
`endif

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tt_uart_baud_tick.sv
// Loadable bit-period down-counter: o_tick_c marks the last clock of each bit period,
// o_next_tick_c predicts that the following clock will be the last one.
module tt_uart_baud_tick #(
    parameter int unsigned DIV_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c,
    output logic             o_next_tick_c
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;

    // Divisor is captured on load so later input changes cannot disturb a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
            r_div <= i_div;
        end else if (r_cnt == '0) begin
            r_cnt <= r_div;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_tick_c = (r_cnt == '0);

    always_comb begin
        if (i_load) begin
            o_next_tick_c = (i_div == '0);
        end else if (r_cnt == '0) begin
            o_next_tick_c = (r_div == '0);
        end else begin
            o_next_tick_c = (r_cnt == DIV_W'(1));
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, STOP_BITS stop bits, per-frame latched divisor.
// Define TT_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int unsigned DIV_W     = 12,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [DIV_W-1:0]          baud_div,
    output logic                      tx,
    output logic                      busy
);

    localparam int unsigned            STOP_CNT_W = 1;
    localparam logic [STOP_CNT_W-1:0]  STOP_LAST  = STOP_CNT_W'(STOP_BITS - 1);
    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

    uart_state_e                r_state, w_state_nxt;
    logic [UART_DATA_BITS-1:0]  r_shift, w_shift_nxt;
    logic [UART_BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [STOP_CNT_W-1:0]      r_stop_cnt, w_stop_cnt_nxt;
    logic                       r_tx, w_tx_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_data_ready, w_data_ready_nxt;
    logic                       w_accept;
    logic                       w_tick;
    logic                       w_next_tick;
`ifdef TT_UART_TX_PARITY_EN
    logic                       r_parity, w_parity_nxt;
`endif

    assign w_accept   = data_valid & r_data_ready;
    assign data_ready = r_data_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;

    tt_uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load        (w_accept),
        .i_div         (baud_div),
        .o_tick_c      (w_tick),
        .o_next_tick_c (w_next_tick)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= '0;
            r_tx         <= UART_IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
`ifdef TT_UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_stop_cnt   <= w_stop_cnt_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_data_ready <= w_data_ready_nxt;
`ifdef TT_UART_TX_PARITY_EN
            r_parity     <= w_parity_nxt;
`endif
        end
    end

    // Next state; every state advances only on the last clock of its bit period.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
`ifdef TT_UART_TX_PARITY_EN
        w_parity_nxt   = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == BIT_LAST) begin
`ifdef TT_UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + UART_BIT_CNT_W'(1);
                        w_shift_nxt   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    end
                end
            end
`ifdef TT_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_nxt = w_accept ? ST_START : ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = STOP_CNT_W'(r_stop_cnt + 1'b1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_accept) begin
            w_shift_nxt    = data_in;
            w_bit_cnt_nxt  = '0;
            w_stop_cnt_nxt = '0;
`ifdef TT_UART_TX_PARITY_EN
            w_parity_nxt   = even_parity(data_in);
`endif
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        w_tx_nxt         = UART_IDLE_LEVEL;
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_data_ready_nxt = (w_state_nxt == ST_IDLE) ||
                           ((w_state_nxt == ST_STOP) && (w_stop_cnt_nxt == STOP_LAST) && w_next_tick);
        case (w_state_nxt)
            ST_START:  w_tx_nxt = ~UART_IDLE_LEVEL;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef TT_UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:   w_tx_nxt = UART_IDLE_LEVEL;
        endcase
    end

endmodule
